// File: rtl/pc_branch_unit.sv
// pc_branch_unit: RV32 fetch-stage program counter with branch/JAL, JALR,
// return-address-stack prediction, trap redirect and target alignment check.
module pc_branch_unit #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_stall,
    input  logic                         i_trap_valid,
    input  logic [XLEN-1:0]              i_trap_vector,
    input  logic                         i_branch_taken,
    input  logic [XLEN-1:0]              i_branch_offset,
    input  logic                         i_jalr,
    input  logic [XLEN-1:0]              i_jalr_base,
    input  logic [XLEN-1:0]              i_jalr_offset,
    input  logic                         i_call,
    input  logic                         i_ret,
    output logic [XLEN-1:0]              o_pc,
    output logic [XLEN-1:0]              o_pc_plus4,
    output logic                         o_misaligned,
    output logic [XLEN-1:0]              o_bad_addr,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  r_pc;
    logic             r_misaligned;
    logic [XLEN-1:0]  r_bad_addr;
    logic [CNT_W-1:0] r_ras_count;
    logic [PTR_W-1:0] r_ras_top;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];

    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_jalr_target;
    logic [XLEN-1:0]  w_br_target;
    logic [XLEN-1:0]  w_target;
    logic             w_redirect;
    logic             w_aligned;
    logic             w_ras_nonempty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_push_idx;
    logic [PTR_W-1:0] w_top_next;
    logic [CNT_W-1:0] w_count_next;

    assign w_pc_plus4     = r_pc + XLEN'(4);
    assign w_jalr_target  = (i_jalr_base + i_jalr_offset) & {{(XLEN-1){1'b1}}, 1'b0};
    assign w_br_target    = r_pc + i_branch_offset;
    assign w_redirect     = i_jalr | i_branch_taken;
    assign w_ras_nonempty = (r_ras_count != CNT_W'(0));

    // Select the redirect target and decide which RAS operations the edge performs.
    always_comb begin
        w_target = w_br_target;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (i_jalr) begin
            w_target = w_jalr_target;
        end else begin
            w_target = w_br_target;
        end
        w_aligned = (w_target[1:0] == 2'b00);
        if (i_trap_valid || i_stall) begin
            w_push = 1'b0;
            w_pop  = 1'b0;
        end else if (w_redirect) begin
            // A JALR that is both call and ret swaps the top entry (pop then push).
            w_push = w_aligned & i_call;
            w_pop  = w_aligned & i_call & i_ret & i_jalr & w_ras_nonempty;
        end else begin
            w_push = 1'b0;
            w_pop  = i_ret & w_ras_nonempty;
        end
    end

    // Compute the next RAS top pointer, write slot and occupancy.
    always_comb begin
        w_push_idx   = r_ras_top + PTR_W'(1);
        w_top_next   = r_ras_top;
        w_count_next = r_ras_count;
        if (w_push && w_pop) begin
            w_push_idx   = r_ras_top;
            w_top_next   = r_ras_top;
            w_count_next = r_ras_count;
        end else if (w_push) begin
            w_top_next = r_ras_top + PTR_W'(1);
            if (r_ras_count == CNT_W'(RAS_DEPTH)) begin
                w_count_next = r_ras_count;
            end else begin
                w_count_next = r_ras_count + CNT_W'(1);
            end
        end else if (w_pop) begin
            w_top_next   = r_ras_top - PTR_W'(1);
            w_count_next = r_ras_count - CNT_W'(1);
        end else begin
            w_top_next   = r_ras_top;
            w_count_next = r_ras_count;
        end
    end

    // RAS storage; contents are meaningless until pushed, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_ras[w_push_idx] <= w_pc_plus4;
        end
    end

    // PC, status and RAS pointer state with trap > stall > jalr/branch > ret > sequential priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc         <= XLEN'(RESET_VECTOR);
            r_misaligned <= 1'b0;
            r_bad_addr   <= '0;
            r_ras_count  <= '0;
            r_ras_top    <= '0;
        end else if (i_trap_valid) begin
            r_pc         <= i_trap_vector;
            r_misaligned <= 1'b0;
            r_ras_count  <= '0;
            r_ras_top    <= '0;
        end else if (i_stall) begin
            r_misaligned <= 1'b0;
        end else if (w_redirect) begin
            if (w_aligned) begin
                r_pc         <= w_target;
                r_misaligned <= 1'b0;
                r_ras_count  <= w_count_next;
                r_ras_top    <= w_top_next;
            end else begin
                r_misaligned <= 1'b1;
                r_bad_addr   <= w_target;
            end
        end else if (w_pop) begin
            r_pc         <= r_ras[r_ras_top];
            r_misaligned <= 1'b0;
            r_ras_count  <= w_count_next;
            r_ras_top    <= w_top_next;
        end else begin
            r_pc         <= w_pc_plus4;
            r_misaligned <= 1'b0;
        end
    end

    assign o_pc         = r_pc;
    assign o_pc_plus4   = w_pc_plus4;
    assign o_misaligned = r_misaligned;
    assign o_bad_addr   = r_bad_addr;
    assign o_ras_count  = r_ras_count;

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Parametrised program-counter unit for the RV32 fetch stage. It owns the PC register and computes sequential, branch/JAL, JALR, return-predicted and trap next-PC values. It adds a return-address stack (RAS), target-alignment checking and stall/trap control on top of the plain PC-plus-offset adder. It sits between decode/execute redirect logic and instruction-memory addressing.

## Interface
- XLEN, 32: address/data width.
- RESET_VECTOR, 32'h00000000: PC value while and after reset.
- RAS_DEPTH, 4: return-address stack entries (power of two, ≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous and active-high.
- stall  in  1  hold PC and RAS.
- trap_valid  in  1  trap redirect.
- trap_vector  in  XLEN  trap target.
- branch_taken  in  1  taken conditional branch or JAL.
- branch_offset  in  XLEN  sign-extended offset, added to the current pc.
- jalr  in  1  register-indirect jump.
- jalr_base  in  XLEN  rs1 value.
- jalr_offset  in  XLEN  sign-extended immediate.
- call  in  1  push the return address (qualifies a jalr or branch_taken redirect).
- ret  in  1  predicted return; pop the RAS.
- pc  out  XLEN  current PC (registered).
- pc_plus4  out  XLEN  pc + 4 (combinational, modulo 2^XLEN).
- misaligned  out  1  one-cycle pulse on a rejected misaligned target.
- bad_addr  out  XLEN  last rejected target (registered).
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.

## Operation
- Next-PC priority, evaluated on each rising edge:
  1. trap_valid: pc <= trap_vector. Overrides stall. Sets ras_count to 0.
  2. stall: pc, RAS and bad_addr hold. misaligned is 0.
  3. jalr: target = (jalr_base + jalr_offset) & ~1.
  4. branch_taken: target = pc + branch_offset.
  5. ret with ras_count > 0: target = top of the RAS; pop.
  6. Otherwise: pc_plus4.
- All additions wrap modulo 2^XLEN. No overflow flag.
- Alignment check for cases 3 and 4: if target[1:0] != 0 (case 3 after clearing bit 0):
  - pc holds.
  - misaligned = 1 for one cycle.
  - bad_addr <= target.
  - No RAS push or pop occurs.
- The RAS is a circular buffer with a top pointer.
  - Push (call with an accepted case 3 or 4 redirect): store the pre-update pc_plus4; ras_count saturates at RAS_DEPTH. When full, the push overwrites the oldest entry.
  - Pop (case 5): decrement the pointer and ras_count.
- call and ret together on an accepted jalr: pop then push. The top entry is replaced; ras_count is unchanged.
- ret with ras_count == 0 falls through to pc_plus4. No error is raised.
- ret is ignored when case 3 or 4 wins.
- call is ignored unless a redirect in case 3 or 4 is accepted.

## Timing
- Reset (asynchronous), values held while rst=1:
  - pc = RESET_VECTOR.
  - ras_count = 0.
  - misaligned = 0.
  - bad_addr = 0.
  - RAS contents: don't-care.
- First edge after rst deasserts: pc = RESET_VECTOR + 4.
- Redirect latency is 1 cycle: inputs sampled at edge N appear on pc after edge N.
- pc_plus4 follows pc combinationally. No other combinational input-to-output paths.
- misaligned is registered and asserted during the cycle after the offending edge.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge.

## Test plan
- Reset/sequential: rst=1 for 3 cycles, then release → pc=0x0 during reset, then 0x4, 0x8, 0xC on successive edges; ras_count=0.
- Negative branch offset: pc=0x0000FF00, branch_taken=1, branch_offset=0xFFFFFFFC → pc=0x0000FEFC. Wrap case: pc=0xFFFFFF00, offset=0x100 → pc=0x00000000.
- Misaligned target: pc=0x10, branch_taken=1, offset=0x2 → pc stays 0x10, misaligned=1 for one cycle, bad_addr=0x12. JALR with base=0x101, offset=0 → target 0x100, accepted.
- RAS call/return: pc=0x100, branch_taken=1, call=1, offset=0x200 → pc=0x300, ras_count=1. Then ret=1 → pc=0x104, ras_count=0. Then ret with an empty RAS → pc=0x108.
- RAS overflow (RAS_DEPTH=4): 5 nested calls with return addresses A1..A5 → ras_count=4. Four rets return A5, A4, A3, A2. The fifth ret falls through to pc+4.
- Stall/trap interaction: stall=1 with branch_taken=1 for 2 cycles → pc unchanged, RAS unchanged. Then trap_valid=1, trap_vector=0x80 while stall=1 → pc=0x80, ras_count=0.
